cmd_frame_parser: RTL and testbench

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/cmd_frame_parser_pkg.sv | 24 ++
 rtl/cmd_frame_parser_if.sv | 32 +++
 rtl/cmd_frame_parser_timeout_cnt.sv | 39 +++
 rtl/cmd_frame_parser.sv | 142 ++++++++++++++
 tb/tb_cmd_frame_parser.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_frame_parser_pkg.sv
// -----------------------------------------------------------------------------
// cmd_frame_parser_pkg
// Shared definitions for the command frame parser and the host-side frame
// builder: parser state encoding, the default head byte and a length check.
// No ports (package).
// -----------------------------------------------------------------------------
package cmd_frame_parser_pkg;

    localparam int         BYTE_W    = 8;
    localparam logic [7:0] HEAD_BYTE = 8'h55;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    // A length byte is usable when it names at least one and at most max_len bytes.
    function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/cmd_frame_parser_if.sv
// -----------------------------------------------------------------------------
// cmd_frame_parser_if
// Byte stream in / decoded command out bundle of the command frame parser.
//   i_rx_data, i_rx_valid      : byte + one-cycle strobe from the UART receiver
//   o_cmd_type, o_cmd_len      : type and length of the last good frame
//   o_cmd_payload              : payload, byte k at [8k+7:8k], unused bytes zero
//   o_cmd_valid, o_frame_err   : one-cycle completion / abort pulses
// Modports: slave = parser side, master = byte source / command consumer side.
// -----------------------------------------------------------------------------
interface cmd_frame_parser_if
    import cmd_frame_parser_pkg::*;
#(
    parameter int P_MAX_LEN = 8
);
    logic [BYTE_W-1:0]           i_rx_data;
    logic                        i_rx_valid;
    logic [BYTE_W-1:0]           o_cmd_type;
    logic [BYTE_W-1:0]           o_cmd_len;
    logic [BYTE_W*P_MAX_LEN-1:0] o_cmd_payload;
    logic                        o_cmd_valid;
    logic                        o_frame_err;

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_cmd_type, o_cmd_len, o_cmd_payload, o_cmd_valid, o_frame_err
    );

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_cmd_type, o_cmd_len, o_cmd_payload, o_cmd_valid, o_frame_err
    );
endinterface

// File: rtl/cmd_frame_parser_timeout_cnt.sv
// -----------------------------------------------------------------------------
// frame_timeout_cnt
// Inter-byte idle counter used while a frame is being received.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : parser is inside a frame; counter is held at zero otherwise
//   i_clr        : a byte arrived this cycle; restart the count
//   o_expired    : count has reached P_TIMEOUT (combinational, same cycle)
// -----------------------------------------------------------------------------
module frame_timeout_cnt #(
    parameter int P_TIMEOUT = 50_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);
    localparam int CW = $clog2(P_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_expired = i_en && (cnt_q == CW'(P_TIMEOUT));

    // Expiry also clears so the count never runs past P_TIMEOUT.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!i_en || i_clr || o_expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cmd_frame_parser.sv
// -----------------------------------------------------------------------------
// cmd_frame_parser
// Parses HEAD / TYPE / LEN / payload frames from a UART byte stream.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : i_rx_data/i_rx_valid in; o_cmd_type, o_cmd_len,
//                  o_cmd_payload, o_cmd_valid, o_frame_err out (all registered)
// A frame aborted by a bad length or an inter-byte timeout pulses o_frame_err;
// a complete frame updates the command outputs and pulses o_cmd_valid.
// -----------------------------------------------------------------------------
module cmd_frame_parser
    import cmd_frame_parser_pkg::*;
#(
    parameter logic [7:0] P_HEAD    = HEAD_BYTE,
    parameter int         P_MAX_LEN = 8,
    parameter int         P_TIMEOUT = 50_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    cmd_frame_parser_if.slave bus
);
    localparam int         PW        = BYTE_W * P_MAX_LEN;
    localparam logic [7:0] MAX_LEN_B = 8'(P_MAX_LEN);

    state_t          state_q, state_d;
    logic [7:0]      type_q, type_d, len_q, len_d, idx_q, idx_d;
    logic [PW-1:0]   stage_q, stage_d;
    logic [7:0]      cmd_type_q, cmd_type_d, cmd_len_q, cmd_len_d;
    logic [PW-1:0]   cmd_payload_q, cmd_payload_d;
    logic            cmd_valid_q, cmd_valid_d, frame_err_q, frame_err_d;
    logic            timeout, last_byte;

    assign last_byte = (idx_q + 8'd1) == len_q;

    frame_timeout_cnt #(
        .P_TIMEOUT (P_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (state_q != ST_IDLE),
        .i_clr     (bus.i_rx_valid),
        .o_expired (timeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Timeout takes priority: a byte arriving in the expiry cycle is dropped.
    // A head byte seen outside IDLE is ordinary data.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ST_IDLE;
        end else if (bus.i_rx_valid) begin
            case (state_q)
                ST_IDLE: if (bus.i_rx_data == P_HEAD) state_d = ST_TYPE;
                ST_TYPE: state_d = ST_LEN;
                ST_LEN:  state_d = len_ok(bus.i_rx_data, MAX_LEN_B) ? ST_DATA : ST_IDLE;
                ST_DATA: if (last_byte) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        type_d        = type_q;
        len_d         = len_q;
        idx_d         = idx_q;
        stage_d       = stage_q;
        cmd_type_d    = cmd_type_q;
        cmd_len_d     = cmd_len_q;
        cmd_payload_d = cmd_payload_q;
        cmd_valid_d   = 1'b0;
        frame_err_d   = 1'b0;
        if (timeout) begin
            frame_err_d = 1'b1;
        end else if (bus.i_rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    // Fresh staging per frame so bytes past a shorter length read zero.
                    if (bus.i_rx_data == P_HEAD) begin
                        stage_d = '0;
                        idx_d   = 8'd0;
                    end
                end
                ST_TYPE: type_d = bus.i_rx_data;
                ST_LEN: begin
                    len_d       = bus.i_rx_data;
                    idx_d       = 8'd0;
                    frame_err_d = !len_ok(bus.i_rx_data, MAX_LEN_B);
                end
                ST_DATA: begin
                    for (int k = 0; k < P_MAX_LEN; k++) begin
                        if (idx_q == 8'(k)) stage_d[k*BYTE_W +: BYTE_W] = bus.i_rx_data;
                    end
                    idx_d = idx_q + 8'd1;
                    if (last_byte) begin
                        cmd_valid_d   = 1'b1;
                        cmd_type_d    = type_q;
                        cmd_len_d     = len_q;
                        cmd_payload_d = stage_d;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            type_q        <= '0;
            len_q         <= '0;
            idx_q         <= '0;
            stage_q       <= '0;
            cmd_type_q    <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            cmd_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            type_q        <= type_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            stage_q       <= stage_d;
            cmd_type_q    <= cmd_type_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.o_cmd_type    = cmd_type_q;
    assign bus.o_cmd_len     = cmd_len_q;
    assign bus.o_cmd_payload = cmd_payload_q;
    assign bus.o_cmd_valid   = cmd_valid_q;
    assign bus.o_frame_err   = frame_err_q;
endmodule

// File: tb/tb_cmd_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_parser
// Directed frames plus randomized byte streams against a byte-list frame model.
// -----------------------------------------------------------------------------
module tb_cmd_frame_parser;
    localparam logic [7:0] HEAD = 8'h55;
    localparam int         MAXL = 8;
    localparam int         PTO  = 20;
    localparam int         PW   = 8 * MAXL;

    logic clk;
    logic rst;

    cmd_frame_parser_if #(.P_MAX_LEN(MAXL)) bus ();

    cmd_frame_parser #(
        .P_HEAD    (HEAD),
        .P_MAX_LEN (MAXL),
        .P_TIMEOUT (PTO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: bytes collected since the head byte, idle gap inside a frame.
    logic [7:0]    fr[$];
    bit            in_frame;
    int            gap;
    logic [7:0]    nxt_type, nxt_len, exp_type, exp_len;
    logic [PW-1:0] nxt_pay, exp_pay;
    logic          nxt_valid, nxt_err, exp_valid, exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the outputs after the coming clock edge from this cycle's inputs.
    task automatic model(input logic v, input logic [7:0] d);
        nxt_valid = 1'b0;
        nxt_err   = 1'b0;
        if (rst) begin
            in_frame = 1'b0;
            gap      = 0;
            fr.delete();
            nxt_type = '0;
            nxt_len  = '0;
            nxt_pay  = '0;
            return;
        end
        if (in_frame && gap == PTO) begin
            nxt_err  = 1'b1;
            in_frame = 1'b0;
            return;
        end
        if (!v) begin
            if (in_frame) gap++;
            return;
        end
        gap = 0;
        if (!in_frame) begin
            if (d == HEAD) begin
                in_frame = 1'b1;
                fr.delete();
            end
            return;
        end
        fr.push_back(d);
        if (fr.size() == 2 && (fr[1] == 8'd0 || int'(fr[1]) > MAXL)) begin
            nxt_err  = 1'b1;
            in_frame = 1'b0;
            return;
        end
        if (fr.size() >= 3 && fr.size() == int'(fr[1]) + 2) begin
            nxt_valid = 1'b1;
            nxt_type  = fr[0];
            nxt_len   = fr[1];
            nxt_pay   = '0;
            for (int k = 0; k < int'(fr[1]); k++) nxt_pay[8*k +: 8] = fr[2+k];
            in_frame  = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        model(v, d);
        @(posedge clk);
        #1;
        exp_valid = nxt_valid;
        exp_err   = nxt_err;
        exp_type  = nxt_type;
        exp_len   = nxt_len;
        exp_pay   = nxt_pay;
        chk_en    = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] q[$]);
        foreach (q[i]) step(1'b1, q[i]);
    endtask

    task automatic lit(input logic [7:0] t, input logic [7:0] l, input logic [PW-1:0] p);
        check("lit_type", 64'(bus.o_cmd_type), 64'(t));
        check("lit_len", 64'(bus.o_cmd_len), 64'(l));
        check("lit_payload", 64'(bus.o_cmd_payload), 64'(p));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.o_cmd_valid) n_valid++;
            if (bus.o_frame_err) n_err++;
            check("cmd_valid", 64'(bus.o_cmd_valid), 64'(exp_valid));
            check("frame_err", 64'(bus.o_frame_err), 64'(exp_err));
            check("cmd_type", 64'(bus.o_cmd_type), 64'(exp_type));
            check("cmd_len", 64'(bus.o_cmd_len), 64'(exp_len));
            check("cmd_payload", 64'(bus.o_cmd_payload), 64'(exp_pay));
        end
    end

    initial begin
        logic [7:0] q[$];
        int v0, e0, kind, len, g;
        logic [7:0] b;
        exp_valid = 1'b0; exp_err = 1'b0; exp_type = '0; exp_len = '0; exp_pay = '0;
        in_frame = 1'b0; gap = 0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = '0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        lit(8'h00, 8'h00, 64'h0);

        // Single one-byte frame
        v0 = n_valid; e0 = n_err;
        q = {8'h55, 8'h01, 8'h01, 8'h08}; send(q); idle(1);
        check("f1_pulses", 64'(n_valid - v0), 64'd1);
        lit(8'h01, 8'h01, 64'h08);

        // Two frames back to back, no gap
        v0 = n_valid;
        q = {8'h55, 8'h05, 8'h01, 8'h01, 8'h55, 8'h05, 8'h01, 8'h01}; send(q); idle(1);
        check("b2b_pulses", 64'(n_valid - v0), 64'd2);
        lit(8'h05, 8'h01, 64'h01);

        // Oversized length, then recovery
        v0 = n_valid; e0 = n_err;
        q = {8'h55, 8'h02, 8'h09}; send(q); idle(1);
        check("badlen_err", 64'(n_err - e0), 64'd1);
        q = {8'h55, 8'h01, 8'h01, 8'h08}; send(q); idle(1);
        check("badlen_recover", 64'(n_valid - v0), 64'd1);
        lit(8'h01, 8'h01, 64'h08);

        // Truncated frame times out, outputs keep the previous frame
        v0 = n_valid; e0 = n_err;
        q = {8'h55, 8'h03, 8'h02, 8'hAA}; send(q); idle(PTO + 2);
        check("timeout_err", 64'(n_err - e0), 64'd1);
        check("timeout_noval", 64'(n_valid - v0), 64'd0);
        lit(8'h01, 8'h01, 64'h08);

        // Byte after PTO-1 idle clocks is still accepted
        v0 = n_valid; e0 = n_err;
        q = {8'h55, 8'h03, 8'h01}; send(q); idle(PTO - 1); step(1'b1, 8'h07); idle(1);
        check("edge_ok", 64'(n_valid - v0), 64'd1);
        lit(8'h03, 8'h01, 64'h07);

        // Byte in the expiry cycle is discarded
        v0 = n_valid; e0 = n_err;
        q = {8'h55, 8'h09, 8'h01}; send(q); idle(PTO); step(1'b1, 8'h0E); idle(2);
        check("edge_to_err", 64'(n_err - e0), 64'd1);
        check("edge_to_noval", 64'(n_valid - v0), 64'd0);

        // Garbage before a frame; head value inside the payload is data
        v0 = n_valid; e0 = n_err;
        q = {8'h00, 8'hFF, 8'h12, 8'h55, 8'h04, 8'h02, 8'h55, 8'h66}; send(q); idle(1);
        check("garbage_noerr", 64'(n_err - e0), 64'd0);
        lit(8'h04, 8'h02, 64'h6655);

        // Reset mid-frame
        v0 = n_valid; e0 = n_err;
        q = {8'h55, 8'h01}; send(q);
        rst = 1'b1; idle(2); rst = 1'b0; idle(1);
        check("rst_nopulse", 64'((n_valid - v0) + (n_err - e0)), 64'd0);
        lit(8'h00, 8'h00, 64'h0);
        q = {8'h55, 8'h01, 8'h01, 8'h08}; send(q); idle(1);
        lit(8'h01, 8'h01, 64'h08);

        // Randomized streams
        for (int f = 0; f < 300; f++) begin
            kind = $urandom_range(0, 9);
            q.delete();
            if (kind == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                    b = 8'($urandom);
                    if (b == HEAD) b = 8'h00;
                    q.push_back(b);
                end
            end else if (kind <= 7) begin
                len = (kind == 7) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 255)))
                                  : int'($urandom_range(1, MAXL));
                q.push_back(HEAD);
                q.push_back(8'($urandom));
                q.push_back(8'(len));
                if (kind != 7) begin
                    for (int i = 0; i < len; i++) q.push_back(($urandom_range(0, 3) == 0) ? HEAD : 8'($urandom));
                    if (kind == 6) void'(q.pop_back());
                end
            end else if (kind == 8) begin
                q = {HEAD, 8'($urandom), 8'(MAXL)};
            end else begin
                q = {HEAD, 8'($urandom)};
                send(q);
                rst = 1'b1; idle(1); rst = 1'b0;
                q.delete();
            end
            foreach (q[i]) begin
                step(1'b1, q[i]);
                g = $urandom_range(0, 39);
                idle(g == 0 ? PTO : g == 1 ? PTO - 1 : g < 20 ? 0 : int'($urandom_range(1, 3)));
            end
            if (kind == 6 || kind == 8) idle(PTO + 2);
        end
        idle(PTO + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
